// File: rtl/if_fetch_unit.sv
// ---------------------------------------------------------------------------
// if_fetch_unit
// Instruction-fetch front end. Owns the fetch PC. Issues at most one
// outstanding request to instruction memory. Queues returned instructions in
// a small FIFO whose head feeds the IF/ID register.
//
// Ports
//   clk, rst        rising-edge clock, synchronous active-high reset
//   redirect_valid  one-cycle redirect pulse from EX (branch/jump/jalr)
//   redirect_pc     redirect target, low two bits ignored
//   imem_req        request strobe, one cycle per request
//   imem_addr       word-aligned fetch address, valid with imem_req
//   imem_rvalid     response strobe, exactly one per request, in order
//   imem_rdata      instruction, valid with imem_rvalid
//   if_valid        buffer head holds a valid instruction
//   if_pc           PC of head instruction (0 while empty)
//   if_instr        head instruction (0 while empty)
//   id_ready        ID accepts head; pop when if_valid && id_ready
// ---------------------------------------------------------------------------
module if_fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int unsigned DEPTH    = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_rvalid,
   input  logic [31:0] imem_rdata,
   output logic        if_valid,
   output logic [31:0] if_pc,
   output logic [31:0] if_instr,
   input  logic        id_ready
);

   localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CW = $clog2(DEPTH + 1);
   localparam logic [31:0] WORD_MASK = ~32'd3;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      DROP = 2'd2
   } state_t;

   state_t        state;
   logic [31:0]   fetch_pc;
   logic [31:0]   req_pc;
   logic [PW-1:0] rd_ptr;
   logic [PW-1:0] wr_ptr;
   logic [CW-1:0] count;

   logic [31:0]   buf_pc    [DEPTH];
   logic [31:0]   buf_instr [DEPTH];

   logic          pop;
   logic          push;
   logic          issue_slot;
   logic          may_issue;
   logic [CW-1:0] count_next;
   logic [PW-1:0] rd_ptr_next;
   logic          head_valid_next;
   logic [31:0]   head_pc_next;
   logic [31:0]   head_instr_next;

   // Per-cycle decisions: pop/push, occupancy after this cycle, issue, next head.
   always_comb begin
      pop             = if_valid && id_ready && !redirect_valid;
      push            = (state == WAIT) && imem_rvalid && !redirect_valid;
      count_next      = count + CW'(push) - CW'(pop);
      if (redirect_valid) begin
         count_next = '0;
      end
      // A response returning this cycle frees the single outstanding slot.
      issue_slot      = (state == IDLE) || ((state == WAIT) && imem_rvalid);
      // Reserve a buffer entry at issue so responses never need back-pressure.
      may_issue       = !redirect_valid && issue_slot && (count_next < CW'(DEPTH));
      rd_ptr_next     = pop ? rd_ptr + PW'(1) : rd_ptr;
      head_valid_next = (count_next != '0);
      head_pc_next    = '0;
      head_instr_next = '0;
      if (head_valid_next) begin
         // Buffer empty after the pop: the head is the entry being pushed now.
         if (count == CW'(pop)) begin
            head_pc_next    = req_pc;
            head_instr_next = imem_rdata;
         end else begin
            head_pc_next    = buf_pc[rd_ptr_next];
            head_instr_next = buf_instr[rd_ptr_next];
         end
      end
   end

   // Fetch FSM, PC, FIFO pointers and registered outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         fetch_pc  <= RESET_PC & WORD_MASK;
         req_pc    <= RESET_PC & WORD_MASK;
         rd_ptr    <= '0;
         wr_ptr    <= '0;
         count     <= '0;
         imem_req  <= 1'b0;
         imem_addr <= RESET_PC & WORD_MASK;
         if_valid  <= 1'b0;
         if_pc     <= '0;
         if_instr  <= '0;
      end else begin
         count    <= count_next;
         if_valid <= head_valid_next;
         if_pc    <= head_pc_next;
         if_instr <= head_instr_next;
         imem_req <= may_issue;

         if (redirect_valid) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            fetch_pc <= redirect_pc & WORD_MASK;
         end else begin
            rd_ptr <= rd_ptr_next;
            if (push) begin
               wr_ptr <= wr_ptr + PW'(1);
            end
         end

         // may_issue is never set during a redirect, so fetch_pc is not contended.
         if (may_issue) begin
            imem_addr <= fetch_pc;
            req_pc    <= fetch_pc;
            fetch_pc  <= fetch_pc + 32'd4;
         end

         if (redirect_valid) begin
            // An outstanding response still has to drain; it is then thrown away.
            case (state)
               WAIT:    state <= imem_rvalid ? IDLE : DROP;
               DROP:    state <= imem_rvalid ? IDLE : DROP;
               default: state <= IDLE;
            endcase
         end else begin
            case (state)
               IDLE: begin
                  if (may_issue) begin
                     state <= WAIT;
                  end
               end
               WAIT: begin
                  if (imem_rvalid) begin
                     state <= may_issue ? WAIT : IDLE;
                  end
               end
               DROP: begin
                  if (imem_rvalid) begin
                     state <= IDLE;
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

   // Fetch buffer storage; contents are qualified by count, so no reset needed.
   always_ff @(posedge clk) begin
      if (!rst && push) begin
         buf_pc[wr_ptr]    <= req_pc;
         buf_instr[wr_ptr] <= imem_rdata;
      end
   end

endmodule
